// File: rtl/uart_tx_scheduler.sv
// Arbitrates two requesters onto one UART transmitter.
// Requester 0 sends bytes; requester 1 sends double-width words as two frames, LS byte first.
module uart_tx_scheduler #(
  parameter int DATA_LENGTH  = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req0_valid_i,
  input  logic [DATA_LENGTH-1:0]     req0_data_i,
  output logic                       req0_ack_o,
  input  logic                       req1_valid_i,
  input  logic [2*DATA_LENGTH-1:0]   req1_data_i,
  output logic                       req1_ack_o,
  output logic [DATA_LENGTH-1:0]     tx_p_data_o,
  output logic                       tx_data_valid_o,
  input  logic                       tx_busy_i,
  output logic                       sched_busy_o,
  output logic                       tx_err_o
);

  localparam logic [3:0] TIMEOUT_C = 4'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       idx_q, idx_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       rr_q, rr_d;
  logic                       src_q, src_d;
  logic [2*DATA_LENGTH-1:0]   shadow_q, shadow_d;
  logic [DATA_LENGTH-1:0]     pdata_q, pdata_d;
  logic                       ack0_q, ack0_d;
  logic                       ack1_q, ack1_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= 1'b0;
      cnt_q    <= 4'd0;
      rr_q     <= 1'b1;
      src_q    <= 1'b0;
      shadow_q <= '0;
      pdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      src_q    <= src_d;
      shadow_q <= shadow_d;
      pdata_q  <= pdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next-state, arbitration and output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    src_d    = src_q;
    shadow_d = shadow_q;
    pdata_d  = pdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!tx_busy_i && (req0_valid_i || req1_valid_i)) begin
          state_d = LOAD;
          idx_d   = 1'b0;
          cnt_d   = 4'd0;
          // rr_q holds the last winner; REQ0 wins a tie unless it won last time
          if (req0_valid_i && (!req1_valid_i || rr_q)) begin
            ack0_d   = 1'b1;
            src_d    = 1'b0;
            rr_d     = 1'b0;
            shadow_d = {{DATA_LENGTH{1'b0}}, req0_data_i};
          end else begin
            ack1_d   = 1'b1;
            src_d    = 1'b1;
            rr_d     = 1'b1;
            shadow_d = req1_data_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        valid_d = 1'b1;
        cnt_d   = 4'd0;
        state_d = WAIT_BUSY;
        if (idx_q) begin
          pdata_d = shadow_q[2*DATA_LENGTH-1:DATA_LENGTH];
        end else begin
          pdata_d = shadow_q[DATA_LENGTH-1:0];
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == TIMEOUT_C) begin
          // Transmitter never started: abandon the whole request
          err_d   = 1'b1;
          cnt_d   = 4'd0;
          idx_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (src_q && !idx_q) begin
            idx_d   = 1'b1;
            state_d = LOAD;
          end else begin
            idx_d   = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign req0_ack_o      = ack0_q;
  assign req1_ack_o      = ack1_q;
  assign tx_p_data_o     = pdata_q;
  assign tx_data_valid_o = valid_q;
  assign sched_busy_o    = busy_q;
  assign tx_err_o        = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural UART_TX busy model.
module tb_uart_tx_scheduler;

  localparam int DL = 8;
  localparam int TO = 4;
  localparam int BUSY_LEN = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0;
  logic [DL-1:0]   req0_data = '0;
  logic            req0_ack;
  logic            req1_valid = 1'b0;
  logic [2*DL-1:0] req1_data = '0;
  logic            req1_ack;
  logic [DL-1:0]   tx_p_data;
  logic            tx_data_valid;
  logic            tx_busy = 1'b0;
  logic            sched_busy;
  logic            tx_err;

  int vectors = 0;
  int miscompares = 0;

  logic [DL-1:0] exp_q[$];
  bit            exp_src_q[$];
  int            pushed = 0;
  int            frames = 0;
  int            acks0 = 0;
  int            acks1 = 0;
  int            errs = 0;
  int            cycle = 0;
  int            busy_cnt = 0;
  int            fall_cyc = 0;
  int            valid_cyc = 0;
  int            err_cyc = 0;
  int            gap_obs = 0;
  int            r0_left = 0;
  int            r1_left = 0;
  bit            stuck = 1'b0;
  logic [DL-1:0] last_data = '0;

  uart_tx_scheduler #(.DATA_LENGTH(DL), .BUSY_TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req0_valid_i    (req0_valid),
    .req0_data_i     (req0_data),
    .req0_ack_o      (req0_ack),
    .req1_valid_i    (req1_valid),
    .req1_data_i     (req1_data),
    .req1_ack_o      (req1_ack),
    .tx_p_data_o     (tx_p_data),
    .tx_data_valid_o (tx_data_valid),
    .tx_busy_i       (tx_busy),
    .sched_busy_o    (sched_busy),
    .tx_err_o        (tx_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One cycle: UART_TX model, scoreboard and requester behaviour, all at the falling edge
  task automatic tick();
    logic [DL-1:0] e;
    bit            s;
    @(negedge clk);
    cycle++;
    if (rst) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else begin
      if (tx_busy && !tx_data_valid) check_eq("hold", {24'd0, tx_p_data}, {24'd0, last_data});
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cycle;
        end
      end
      if (tx_data_valid) begin
        frames++;
        valid_cyc = cycle;
        gap_obs   = cycle - fall_cyc;
        check_eq("frame_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("frame_data", {24'd0, tx_p_data}, {24'd0, e});
        end
        last_data = tx_p_data;
        if (!stuck) begin
          tx_busy  = 1'b1;
          busy_cnt = BUSY_LEN;
        end
      end
      if (req0_ack || req1_ack) begin
        check_eq("ack_pending", {31'd0, exp_src_q.size() > 0}, 32'd1);
        if (exp_src_q.size() > 0) begin
          s = exp_src_q.pop_front();
          check_eq("ack_src", {30'd0, req1_ack, req0_ack}, s ? 32'd2 : 32'd1);
        end
      end
      if (req0_ack) begin
        acks0++;
        if (r0_left > 0) r0_left--;
        if (r0_left == 0) req0_valid = 1'b0;
      end
      if (req1_ack) begin
        acks1++;
        if (r1_left > 0) r1_left--;
        if (r1_left == 0) req1_valid = 1'b0;
      end
      if (tx_err) begin
        errs++;
        err_cyc = cycle;
      end
    end
  endtask

  task automatic push_byte(input logic [DL-1:0] b);
    exp_q.push_back(b);
    pushed++;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !sched_busy && !tx_busy && !req0_valid && !req1_valid;
    end
    check_eq("drain", {31'd0, done}, 32'd1);
    check_eq("acks_drained", exp_src_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out"}, {21'd0, req0_ack, req1_ack, tx_data_valid, tx_p_data, sched_busy, tx_err}, 32'd0);
  endtask

  initial begin
    int f0, a0, e0;
    bit seen;

    // Reset held with a byte request pending
    req0_data  = 8'hA7;
    req0_valid = 1'b1;
    r0_left    = 1;
    push_byte(8'hA7);
    exp_src_q.push_back(1'b0);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_eq("rel_ack0", {31'd0, req0_ack}, 32'd1);
    check_eq("rel_valid_early", {31'd0, tx_data_valid}, 32'd0);
    check_eq("rel_sched_busy", {31'd0, sched_busy}, 32'd1);
    tick();
    check_eq("rel_ack0_pulse", {31'd0, req0_ack}, 32'd0);
    check_eq("rel_valid", {31'd0, tx_data_valid}, 32'd1);
    wait_idle(100);

    // Single byte 0x55; SCHED_BUSY drops the cycle after Busy falls
    f0 = frames;
    req0_data  = 8'h55;
    req0_valid = 1'b1;
    r0_left    = 1;
    push_byte(8'h55);
    exp_src_q.push_back(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = (frames > f0) && !tx_busy && busy_cnt == 0 && fall_cyc == cycle;
    end
    check_eq("b55_fall_seen", {31'd0, seen}, 32'd1);
    check_eq("b55_sb_high", {31'd0, sched_busy}, 32'd1);
    tick();
    check_eq("b55_sb_low", {31'd0, sched_busy}, 32'd0);
    wait_idle(50);
    check_eq("b55_one_frame", frames - f0, 32'd1);

    // Word 0xA53C: two frames, LS byte first, 1-cycle gap
    f0 = frames;
    a0 = acks1;
    req1_data  = 16'hA53C;
    req1_valid = 1'b1;
    r1_left    = 1;
    push_byte(8'h3C);
    push_byte(8'hA5);
    exp_src_q.push_back(1'b1);
    wait_idle(100);
    check_eq("word_frames", frames - f0, 32'd2);
    check_eq("word_one_ack", acks1 - a0, 32'd1);
    check_eq("word_gap", gap_obs, 32'd2);

    // Both requesters held together: round robin, REQ0 first after reset
    apply_reset();
    req0_data  = 8'h11;
    req1_data  = 16'h2233;
    r0_left    = 2;
    r1_left    = 2;
    for (int k = 0; k < 2; k++) begin
      push_byte(8'h11);
      push_byte(8'h33);
      push_byte(8'h22);
      exp_src_q.push_back(1'b0);
      exp_src_q.push_back(1'b1);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_idle(200);

    // UART_TX never raises Busy: timeout error, then normal service
    e0 = errs;
    stuck = 1'b1;
    req0_data  = 8'h77;
    req0_valid = 1'b1;
    r0_left    = 1;
    push_byte(8'h77);
    exp_src_q.push_back(1'b0);
    wait_idle(60);
    check_eq("to_err_count", errs - e0, 32'd1);
    check_eq("to_err_delay", err_cyc - valid_cyc, TO);
    stuck = 1'b0;
    f0 = frames;
    req0_data  = 8'h99;
    req0_valid = 1'b1;
    r0_left    = 1;
    push_byte(8'h99);
    exp_src_q.push_back(1'b0);
    wait_idle(60);
    check_eq("to_recover_frame", frames - f0, 32'd1);
    check_eq("to_no_new_err", errs - e0, 32'd1);

    // Reset during WAIT_DONE of the first byte of a word
    req1_data  = 16'hBEEF;
    req1_valid = 1'b1;
    r1_left    = 1;
    push_byte(8'hEF);
    exp_src_q.push_back(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = tx_busy;
    end
    check_eq("mid_busy_seen", {31'd0, seen}, 32'd1);
    tick();
    tick();
    tick();
    check_eq("mid_in_frame", {31'd0, sched_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    tick();
    a0 = acks0;
    req0_data  = 8'h42;
    req0_valid = 1'b1;
    r0_left    = 1;
    push_byte(8'h42);
    exp_src_q.push_back(1'b0);
    rst = 1'b0;
    tick();
    check_eq("mid_fresh_ack0", {31'd0, req0_ack}, 32'd1);
    wait_idle(100);
    check_eq("mid_acks0", acks0 - a0, 32'd1);
    check_eq("frames_vs_pushed", frames, pushed);
    check_eq("err_total", errs, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
